// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pooling over a row-major stream of signed elements.
// Each even row stores its horizontal pair maxima in a half-width line buffer.
// Each odd row combines its own pairs with that buffer into one pooled output.
// The output is a single-entry registered slot with valid/ready backpressure.
`timescale 1ns/1ps

module max_pool_2x2 #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_COLS   = 32,
    parameter int DIM_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  cfg_cols,
    input  logic [DIM_WIDTH-1:0]  cfg_rows,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    localparam int LB_DEPTH = (MAX_COLS / 2 > 0) ? MAX_COLS / 2 : 1;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                       state_q;
    logic [DIM_WIDTH-1:0]         cols_q;
    logic [DIM_WIDTH-1:0]         rows_q;
    logic [DIM_WIDTH-1:0]         col_q;
    logic [DIM_WIDTH-1:0]         row_q;
    logic signed [DATA_WIDTH-1:0] pix_q;
    logic signed [DATA_WIDTH-1:0] out_data_q;
    logic                         out_valid_q;
    logic                         busy_q;
    logic                         done_q;

    logic signed [DATA_WIDTH-1:0] line_buf [LB_DEPTH];

    // Odd sizes are truncated to even by dropping bit 0.
    logic [DIM_WIDTH-1:0]         cols_d;
    logic [DIM_WIDTH-1:0]         rows_d;
    logic signed [DATA_WIDTH-1:0] in_s;
    logic signed [DATA_WIDTH-1:0] pair_max_d;
    logic signed [DATA_WIDTH-1:0] pool_max_d;
    logic [LB_AW-1:0]             lb_idx;
    logic                         xfer;
    logic                         last_col;
    logic                         last_row;
    logic                         load_out;
    logic                         lb_write;
    logic                         out_stalled;

    // Signed maximum; on a tie either operand is the same value.
    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

    assign cols_d      = cfg_cols & ~DIM_ONE;
    assign rows_d      = cfg_rows & ~DIM_ONE;
    assign in_s        = in_data;
    assign lb_idx      = LB_AW'(col_q >> 1);
    assign out_stalled = out_valid_q && !out_ready;
    assign in_ready    = (state_q == S_RUN) && !out_stalled;
    assign xfer        = in_valid && in_ready;
    assign last_col    = (col_q == cols_q - DIM_ONE);
    assign last_row    = (row_q == rows_q - DIM_ONE);
    assign pair_max_d  = smax(pix_q, in_s);
    assign pool_max_d  = smax(pair_max_d, line_buf[lb_idx]);
    assign lb_write    = xfer && col_q[0] && !row_q[0];
    assign load_out    = xfer && col_q[0] && row_q[0];

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Control FSM, stream counters, pixel register and output slot.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order inside the block.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            cols_q      <= '0;
            rows_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pix_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // A new result wins over a same-cycle drain, keeping valid high.
            if (load_out) begin
                out_valid_q <= 1'b1;
                out_data_q  <= pool_max_d;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (xfer) begin
                if (!col_q[0]) begin
                    pix_q <= in_s;
                end
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_q + DIM_ONE;
                end else begin
                    col_q <= col_q + DIM_ONE;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cols_q <= cols_d;
                        rows_q <= rows_d;
                        col_q  <= '0;
                        row_q  <= '0;
                        busy_q <= 1'b1;
                        if (cols_d == '0 || rows_d == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (xfer && last_col && last_row) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (!out_valid_q || out_ready) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Line buffer of even-row pair maxima, one entry per column pair.
    // NOTE: storage is deliberately not reset; every entry is written on an
    // even row before the following odd row reads it, so stale data is harmless.
    always_ff @(posedge clk) begin
        if (lb_write) begin
            line_buf[lb_idx] <= pair_max_d;
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2: directed maps plus random maps with gaps and
// backpressure, compared against a direct 2x2-window maximum model.
`timescale 1ns/1ps

module tb_max_pool_2x2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] cfg_cols;
    logic [5:0] cfg_rows;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic signed [7:0] img [0:255];
    logic [7:0]        got[$];
    logic [7:0]        exp_q[$];

    max_pool_2x2 #(.DATA_WIDTH(8), .MAX_COLS(32), .DIM_WIDTH(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_cols  (cfg_cols),
        .cfg_rows  (cfg_rows),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: maximum of each non-overlapping 2x2 window, row-major.
    task automatic build_model(input int c, input int r);
        exp_q.delete();
        for (int y = 0; y < r; y += 2) begin
            for (int x = 0; x < c; x += 2) begin
                logic signed [7:0] m;
                m = img[y*c + x];
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++)
                        if (img[(y+dy)*c + x + dx] > m) m = img[(y+dy)*c + x + dx];
                exp_q.push_back(m);
            end
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) img[i] = 8'($urandom);
    endtask

    // Runs one pass. gap: random in_valid gaps; rnd_ready: random out_ready;
    // stall_len: hold out_ready low that many cycles on the first output;
    // start_at: cycle of a stray start pulse (-1 none); abort_after: stop
    // driving once that many elements were accepted (-1 run to completion).
    task automatic run_pass(input string tag, input int cfg_c, input int cfg_r,
                            input int gap, input int rnd_ready, input int stall_len,
                            input int start_at, input int abort_after);
        int c, r, n, idx, cyc, n_done, stall_cnt, last_in, done_cyc;
        bit stop, prev_stall;
        logic [7:0] prev_data;
        c = cfg_c & ~1;
        r = cfg_r & ~1;
        n = c * r;
        idx = 0; cyc = 0; n_done = 0; stall_cnt = 0;
        last_in = -1; done_cyc = -1; stop = 0; prev_stall = 0; prev_data = '0;
        build_model(c, r);
        got.delete();

        @(negedge clk);
        start = 1'b1; cfg_cols = 6'(cfg_c); cfg_rows = 6'(cfg_r);
        @(negedge clk);
        start = 1'b0;

        while (!stop && n_done == 0 && cyc < 3000) begin
            if (abort_after >= 0 && idx == abort_after) begin
                stop = 1;
            end else begin
                start = (cyc == start_at);
                if (start) begin
                    cfg_cols = 6'd2; cfg_rows = 6'd2;
                end
                if (stall_len > 0 && out_valid && got.size() == 0 && stall_cnt < stall_len) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else if (rnd_ready != 0) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                end else begin
                    out_ready = 1'b1;
                end
                in_valid = (idx < n) && (gap == 0 || $urandom_range(0, 3) != 0);
                in_data  = in_valid ? img[idx] : 8'($urandom);
                #1;
                if (prev_stall) begin
                    check({tag, ":hold_valid"}, out_valid, 1);
                    check({tag, ":hold_data"}, out_data, prev_data);
                end
                if (out_valid && !out_ready) check({tag, ":stall_in_ready"}, in_ready, 0);
                if (out_valid && out_ready) got.push_back(out_data);
                if (in_valid && in_ready) begin
                    idx++;
                    last_in = cyc;
                end
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;

        if (abort_after < 0) begin
            in_valid = 1'b0;
            check({tag, ":done_seen"}, n_done, 1);
            #1;
            check({tag, ":done_pulse"}, done, 0);
            check({tag, ":idle_busy"}, busy, 0);
            check({tag, ":count"}, got.size(), exp_q.size());
            for (int i = 0; i < got.size() && i < exp_q.size(); i++)
                check({tag, ":data"}, got[i], exp_q[i]);
            if (gap == 0 && rnd_ready == 0 && stall_len == 0)
                check({tag, ":done_lat"}, done_cyc - last_in, 2);
        end
    endtask

    initial begin
        int done_at;
        bit seen_valid;

        rst_n = 1'b1; start = 1'b0; cfg_cols = '0; cfg_rows = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // 4x4 ramp: expect 5,7,13,15 and done two samples after the last input.
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
        run_pass("ramp4x4", 4, 4, 0, 0, 0, -1, -1);
        check("ramp_size", got.size(), 4);
        if (got.size() == 4) begin
            check("ramp_o0", got[0], 8'd5);
            check("ramp_o1", got[1], 8'd7);
            check("ramp_o2", got[2], 8'd13);
            check("ramp_o3", got[3], 8'd15);
        end

        // 2x2 negative values: signed maximum is -1.
        img[0] = -8'sd3; img[1] = -8'sd1; img[2] = -8'sd8; img[3] = -8'sd2;
        run_pass("neg2x2", 2, 2, 0, 0, 0, -1, -1);
        if (got.size() == 1) check("neg_o0", got[0], 8'hFF);

        // 4x2 with the first output stalled for 5 cycles.
        fill_random(8);
        run_pass("stall4x2", 4, 2, 0, 0, 5, -1, -1);

        // Zero-size configuration: done quickly, never any output.
        @(negedge clk);
        start = 1'b1; cfg_cols = 6'd0; cfg_rows = 6'd4;
        @(negedge clk);
        start = 1'b0;
        done_at = -1; seen_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            if (done && done_at < 0) done_at = k;
            if (out_valid) seen_valid = 1;
            @(negedge clk);
        end
        check("zero_done_in_2", (done_at >= 1 && done_at <= 2), 1);
        check("zero_no_output", seen_valid, 0);

        // Stray start during RUN is ignored.
        fill_random(16);
        run_pass("start_in_run", 4, 4, 0, 0, 0, 5, -1);

        // Odd sizes truncate: 5x3 behaves as 4x2.
        fill_random(8);
        run_pass("trunc5x3", 5, 3, 1, 1, 0, -1, -1);

        // Reset mid-pass after 6 elements of a 4x4 map.
        fill_random(16);
        run_pass("abort4x4", 4, 4, 0, 0, 0, -1, 6);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b0;
        seen_valid = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            #1;
            if (out_valid || in_ready || done) seen_valid = 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("abort_quiet", seen_valid, 0);
        img[0] = 8'sd1; img[1] = 8'sd9; img[2] = 8'sd4; img[3] = 8'sd2;
        run_pass("after_abort", 2, 2, 0, 0, 0, -1, -1);
        if (got.size() == 1) check("after_abort_o0", got[0], 8'd9);

        // Widest row.
        fill_random(64);
        run_pass("maxcols32x2", 32, 2, 1, 1, 0, -1, -1);

        // Random maps with gaps and backpressure, back to back.
        for (int t = 0; t < 6; t++) begin
            int rc, rr;
            rc = 2 * $urandom_range(1, 4);
            rr = 2 * $urandom_range(1, 4);
            fill_random(rc * rr);
            run_pass("random", rc, rr, 1, 1, 0, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 Parameter DATA_WIDTH, default 8, signed width of each feature-map element.
REQ-002 Parameter MAX_COLS, default 32, maximum input row length in elements, even.
REQ-003 Parameter DIM_WIDTH, default 6, width of the dimension and counter fields.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-006 start  input  1  one-cycle pulse that begins a feature-map pass.
REQ-007 cfg_cols  input  DIM_WIDTH  input columns per row, even, 2..MAX_COLS.
REQ-008 cfg_rows  input  DIM_WIDTH  input rows per map, even, >=2.
REQ-009 in_valid  input  1  in_data carries a valid element (RELU output, row-major).
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 in_data  input  DATA_WIDTH  signed input element.
REQ-012 out_valid  output  1  out_data holds a pooled element.
REQ-013 out_ready  input  1  downstream (OFM buffer) accepts out_data this cycle.
REQ-014 out_data  output  DATA_WIDTH  signed 2x2 maximum.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at end of a pass.

Function
REQ-017 The block SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-018 IDLE->RUN on start; cfg_cols/cfg_rows SHALL be latched that cycle; start SHALL be ignored outside IDLE.
REQ-019 If latched cfg_cols or cfg_rows is 0, IDLE->DONE directly, with no output.
REQ-020 cfg_cols[0] and cfg_rows[0] SHALL be treated as 0 (odd sizes truncated to even).
REQ-021 An element SHALL transfer only on a cycle with in_valid && in_ready.
REQ-022 in_ready SHALL equal (state==RUN) && !(out_valid && !out_ready).
REQ-023 Column and row counters SHALL advance per transfer, column wrapping to 0 at cols-1 and row incrementing.
REQ-024 Even row, odd column: max(previous element, current) SHALL be written to line-buffer entry col/2.
REQ-025 Odd row, odd column: max(previous element, current, line-buffer entry col/2) SHALL be loaded into out_data with out_valid=1 on the next cycle.
REQ-026 Even columns SHALL only be held in a single pixel register.
REQ-027 All comparisons SHALL be signed two's-complement; ties SHALL return the equal value; no width growth.
REQ-028 out_valid SHALL stay high with out_data stable until out_valid && out_ready; it then clears unless a new result loads the same cycle.
REQ-029 Load and drain on the same cycle SHALL keep out_valid=1 with the new value.
REQ-030 After the final element (row rows-1, col cols-1), RUN->FLUSH.
REQ-031 FLUSH->DONE once out_valid is 0 or drains that cycle.
REQ-032 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-033 Output count per pass SHALL be exactly (cols/2)*(rows/2), in row-major order.
REQ-034 Line-buffer contents SHALL need no clearing between passes.

Reset
REQ-035 While rst_n=1: state=IDLE; counters=0; out_valid=0; out_data=0; in_ready=0; busy=0; done=0.
REQ-036 Reset asserted mid-pass SHALL abort immediately; no further outputs SHALL appear until the next start.

Verification
REQ-037 4x4 map, values 0..15 row-major, out_ready=1 -> outputs 5,7,13,15, then a done pulse one cycle after FLUSH.
REQ-038 2x2 map {-3,-1,-8,-2} -> single output -1 (signed compare).
REQ-039 4x2 map, out_ready held 0 for 5 cycles after the first output -> in_ready=0 while stalled, out_data stable, no loss, 2 outputs total.
REQ-040 start with cfg_cols=0 -> done in 2 cycles, out_valid never asserted; start pulsed during RUN -> ignored, counts unchanged.
REQ-041 rst_n=1 after 6 elements of a 4x4 pass -> all outputs 0 next edge; a new 2x2 pass {1,9,4,2} -> output 9.
